// File: rtl/eth_avalon_rxdma_burst_ctrl.sv
// RX DMA read-side sequencer: drains show-ahead FIFO words into Avalon-MM write bursts
// and reports per-frame byte count, overflow and error status.
module eth_avalon_rxdma_burst_ctrl #(
    parameter int unsigned BURST       = 8,
    parameter int unsigned FIFO_WIDTHU = 11,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         desc_valid_i,
    input  logic [ADDR_W-1:0]            desc_addr_i,
    input  logic [15:0]                  desc_len_i,
    output logic                         desc_ready_o,
    input  logic                         frame_done_i,
    input  logic [35:0]                  fifo_q_i,
    input  logic                         fifo_rdempty_i,
    input  logic [FIFO_WIDTHU-1:0]       fifo_rdusedw_i,
    output logic                         fifo_rdreq_o,
    output logic [ADDR_W-1:0]            av_address_o,
    output logic                         av_write_o,
    output logic [$clog2(BURST):0]       av_burstcount_o,
    output logic [31:0]                  av_writedata_o,
    output logic [3:0]                   av_byteenable_o,
    input  logic                         av_waitrequest_i,
    output logic                         done_o,
    output logic [15:0]                  done_bytes_o,
    output logic                         done_ovf_o,
    output logic                         done_err_o
);

    localparam int unsigned BcW  = $clog2(BURST) + 1;
    localparam int unsigned RemW = 15;
    localparam int unsigned CntW = 17;

    typedef enum logic [2:0] {StIdle, StWait, StBurst, StDiscard, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [RemW-1:0]     rem_q, rem_d;
    logic [15:0]         bytes_q, bytes_d;
    logic                err_q, err_d;
    logic                ovf_q, ovf_d;
    logic                pad_q, pad_d;
    logic [BcW-1:0]      beats_left_q, beats_left_d;
    logic [BcW-1:0]      real_cnt_q, real_cnt_d;
    logic                av_write_q, av_write_d;
    logic [ADDR_W-1:0]   av_address_q, av_address_d;
    logic [BcW-1:0]      av_burstcount_q, av_burstcount_d;
    logic [31:0]         av_writedata_q, av_writedata_d;
    logic [3:0]          av_byteenable_q, av_byteenable_d;
    logic                done_q, done_d;
    logic [15:0]         done_bytes_q, done_bytes_d;
    logic                done_ovf_q, done_ovf_d;
    logic                done_err_q, done_err_d;
    logic                desc_ready_q, desc_ready_d;

    logic                accept;
    logic                beat_real;
    logic                beat_eop;
    logic                burst_last;
    logic                start_burst;
    logic [CntW-1:0]     used_ext;
    logic [CntW-1:0]     n_c;
    logic [2:0]          beat_inc;
    logic [16:0]         bytes_sum;
    logic [15:0]         bytes_sat;
    logic [3:0]          eop_be;
    logic [3:0]          load_be;
    logic [BcW-1:0]      real_total;

    // Burst sizing: n = min(BURST, words available, buffer words remaining)
    always_comb begin
        used_ext = CntW'(fifo_rdusedw_i);
        n_c      = CntW'(BURST);
        if (used_ext < n_c) begin
            n_c = used_ext;
        end
        if (CntW'(rem_q) < n_c) begin
            n_c = CntW'(rem_q);
        end
        start_burst = ((used_ext >= CntW'(BURST)) || (frame_done_i && !fifo_rdempty_i))
                      && (used_ext != '0) && (rem_q != '0);
    end

    always_comb begin
        case (fifo_q_i[34:33])
            2'd0:    eop_be = 4'b0001;
            2'd1:    eop_be = 4'b0011;
            2'd2:    eop_be = 4'b0111;
            default: eop_be = 4'b1111;
        endcase
        load_be   = fifo_q_i[32] ? eop_be : 4'hF;
        beat_inc  = fifo_q_i[32] ? ({1'b0, fifo_q_i[34:33]} + 3'd1) : 3'd4;
        bytes_sum = {1'b0, bytes_q} + {14'd0, beat_inc};
        bytes_sat = bytes_sum[16] ? 16'hFFFF : bytes_sum[15:0];
    end

    // Once the EOP beat is out, the rest of the committed burst is padding
    assign accept     = av_write_q & ~av_waitrequest_i;
    assign beat_real  = ~pad_q;
    assign beat_eop   = beat_real & fifo_q_i[32];
    assign burst_last = (beats_left_q == BcW'(1));
    assign real_total = real_cnt_q + BcW'(beat_real);

    // Gated by reset so an abandoned burst never consumes a FIFO word
    assign fifo_rdreq_o = ~reset_i & ~fifo_rdempty_i &
                          (((state_q == StBurst) & accept & beat_real) |
                           (state_q == StDiscard));

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        bytes_d         = bytes_q;
        err_d           = err_q;
        ovf_d           = ovf_q;
        pad_d           = pad_q;
        beats_left_d    = beats_left_q;
        real_cnt_d      = real_cnt_q;
        av_write_d      = av_write_q;
        av_address_d    = av_address_q;
        av_burstcount_d = av_burstcount_q;
        av_writedata_d  = av_writedata_q;
        av_byteenable_d = av_byteenable_q;
        done_d          = 1'b0;
        done_bytes_d    = done_bytes_q;
        done_ovf_d      = done_ovf_q;
        done_err_d      = done_err_q;

        case (state_q)
            StIdle: begin
                if (desc_valid_i) begin
                    addr_d  = {desc_addr_i[ADDR_W-1:2], 2'b00};
                    rem_d   = RemW'((CntW'(desc_len_i) + CntW'(3)) >> 2);
                    bytes_d = '0;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = (desc_len_i == '0) ? StDiscard : StWait;
                end
            end
            StWait: begin
                if (rem_q == '0) begin
                    if (!fifo_rdempty_i) begin
                        state_d = StDiscard;
                    end
                end else if (start_burst) begin
                    av_address_d    = addr_q;
                    av_burstcount_d = BcW'(n_c);
                    beats_left_d    = BcW'(n_c);
                    real_cnt_d      = '0;
                    pad_d           = 1'b0;
                    av_write_d      = 1'b1;
                    av_writedata_d  = fifo_q_i[31:0];
                    av_byteenable_d = load_be;
                    state_d         = StBurst;
                end
            end
            StBurst: begin
                if (av_write_q) begin
                    if (!av_waitrequest_i) begin
                        real_cnt_d = real_total;
                        if (beat_real) begin
                            bytes_d = bytes_sat;
                            err_d   = err_q | fifo_q_i[35];
                        end
                        if (beat_eop) begin
                            pad_d = 1'b1;
                        end
                        if (burst_last) begin
                            av_write_d      = 1'b0;
                            av_byteenable_d = '0;
                            addr_d          = addr_q + (ADDR_W'(av_burstcount_q) << 2);
                            rem_d           = rem_q - RemW'(real_total);
                            if (pad_q || beat_eop) begin
                                state_d = StDone;
                            end else if (rem_q == RemW'(real_total)) begin
                                state_d = StDiscard;
                            end else begin
                                state_d = StWait;
                            end
                        end else begin
                            beats_left_d = beats_left_q - BcW'(1);
                            if (pad_q || beat_eop) begin
                                av_writedata_d  = '0;
                                av_byteenable_d = '0;
                            end else begin
                                // Show-ahead data refreshes one cycle after the pop
                                av_write_d = 1'b0;
                            end
                        end
                    end
                end else if (!fifo_rdempty_i) begin
                    av_write_d      = 1'b1;
                    av_writedata_d  = fifo_q_i[31:0];
                    av_byteenable_d = load_be;
                end
            end
            StDiscard: begin
                ovf_d = 1'b1;
                if (!fifo_rdempty_i) begin
                    err_d = err_q | fifo_q_i[35];
                    if (fifo_q_i[32]) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                done_d       = 1'b1;
                done_bytes_d = bytes_q;
                done_ovf_d   = ovf_q;
                done_err_d   = err_q;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        desc_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            rem_q           <= '0;
            bytes_q         <= '0;
            err_q           <= 1'b0;
            ovf_q           <= 1'b0;
            pad_q           <= 1'b0;
            beats_left_q    <= '0;
            real_cnt_q      <= '0;
            av_write_q      <= 1'b0;
            av_address_q    <= '0;
            av_burstcount_q <= '0;
            av_writedata_q  <= '0;
            av_byteenable_q <= '0;
            done_q          <= 1'b0;
            done_bytes_q    <= '0;
            done_ovf_q      <= 1'b0;
            done_err_q      <= 1'b0;
            desc_ready_q    <= 1'b1;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            bytes_q         <= bytes_d;
            err_q           <= err_d;
            ovf_q           <= ovf_d;
            pad_q           <= pad_d;
            beats_left_q    <= beats_left_d;
            real_cnt_q      <= real_cnt_d;
            av_write_q      <= av_write_d;
            av_address_q    <= av_address_d;
            av_burstcount_q <= av_burstcount_d;
            av_writedata_q  <= av_writedata_d;
            av_byteenable_q <= av_byteenable_d;
            done_q          <= done_d;
            done_bytes_q    <= done_bytes_d;
            done_ovf_q      <= done_ovf_d;
            done_err_q      <= done_err_d;
            desc_ready_q    <= desc_ready_d;
        end
    end

    assign desc_ready_o    = desc_ready_q;
    assign av_address_o    = av_address_q;
    assign av_write_o      = av_write_q;
    assign av_burstcount_o = av_burstcount_q;
    assign av_writedata_o  = av_writedata_q;
    assign av_byteenable_o = av_byteenable_q;
    assign done_o          = done_q;
    assign done_bytes_o    = done_bytes_q;
    assign done_ovf_o      = done_ovf_q;
    assign done_err_o      = done_err_q;

endmodule

// File: tb/tb_eth_avalon_rxdma_burst_ctrl.sv
// Scoreboard bench for eth_avalon_rxdma_burst_ctrl: a queue-based FIFO model feeds the DUT,
// expected beats/completions are queued by the stimulus and checked by a negedge monitor.
module tb_eth_avalon_rxdma_burst_ctrl;

    localparam int BURST = 8;
    localparam int FW    = 11;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          desc_valid = 1'b0;
    logic [AW-1:0] desc_addr = '0;
    logic [15:0]   desc_len = '0;
    logic          desc_ready;
    logic          frame_done = 1'b0;
    logic [35:0]   fifo_q = '0;
    logic          fifo_rdempty = 1'b1;
    logic [FW-1:0] fifo_rdusedw = '0;
    logic          fifo_rdreq;
    logic [AW-1:0] av_address;
    logic          av_write;
    logic [3:0]    av_burstcount;
    logic [31:0]   av_writedata;
    logic [3:0]    av_byteenable;
    logic          av_waitrequest = 1'b0;
    logic          done;
    logic [15:0]   done_bytes;
    logic          done_ovf;
    logic          done_err;

    always #5 clk = ~clk;

    eth_avalon_rxdma_burst_ctrl #(
        .BURST       (BURST),
        .FIFO_WIDTHU (FW),
        .ADDR_W      (AW)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .desc_valid_i     (desc_valid),
        .desc_addr_i      (desc_addr),
        .desc_len_i       (desc_len),
        .desc_ready_o     (desc_ready),
        .frame_done_i     (frame_done),
        .fifo_q_i         (fifo_q),
        .fifo_rdempty_i   (fifo_rdempty),
        .fifo_rdusedw_i   (fifo_rdusedw),
        .fifo_rdreq_o     (fifo_rdreq),
        .av_address_o     (av_address),
        .av_write_o       (av_write),
        .av_burstcount_o  (av_burstcount),
        .av_writedata_o   (av_writedata),
        .av_byteenable_o  (av_byteenable),
        .av_waitrequest_i (av_waitrequest),
        .done_o           (done),
        .done_bytes_o     (done_bytes),
        .done_ovf_o       (done_ovf),
        .done_err_o       (done_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  bc;
        logic [31:0] data;
        logic [3:0]  be;
        bit          chk_data;
    } beat_t;

    typedef struct {
        logic [15:0] bytes;
        logic        ovf;
        logic        err;
    } done_t;

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } chk_t;

    beat_t       exp_beats[$];
    done_t       exp_done[$];
    chk_t        chk_q[$];
    logic [35:0] fq[$];

    int nvec = 0;
    int nmis = 0;
    int acc_cnt = 0;
    int pop_cnt = 0;
    int done_cnt = 0;
    bit pop_pending = 1'b0;
    bit stall_en = 1'b0;

    beat_t mb;
    done_t md;
    chk_t  mc;

    function automatic logic [35:0] mkw(input logic [31:0] d, input logic eop,
                                        input logic [1:0] bf, input logic er);
        return {er, bf, eop, d};
    endfunction

    task automatic push(input logic [35:0] w);
        fq.push_back(w);
    endtask

    task automatic exp_beat(input logic [31:0] addr, input logic [3:0] bc,
                            input logic [31:0] data, input logic [3:0] be, input bit chk);
        beat_t b;
        b.addr = addr; b.bc = bc; b.data = data; b.be = be; b.chk_data = chk;
        exp_beats.push_back(b);
    endtask

    task automatic exp_fin(input logic [15:0] bytes, input logic ovf, input logic err);
        done_t d;
        d.bytes = bytes; d.ovf = ovf; d.err = err;
        exp_done.push_back(d);
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_t c;
        c.name = nm; c.act = act; c.exp = exp;
        chk_q.push_back(c);
    endtask

    // FIFO model: pop decided at the preceding negedge, show-ahead word updates after the edge
    always @(posedge clk) begin
        #1;
        if (pop_pending && fq.size() > 0) void'(fq.pop_front());
        if (fq.size() > 0) fifo_q = fq[0];
        else fifo_q = 36'h0;
        fifo_rdempty = (fq.size() == 0);
        fifo_rdusedw = FW'(fq.size());
        av_waitrequest = stall_en ? 1'($urandom_range(1, 0)) : 1'b0;
    end

    // Monitor: sole owner of the comparison counters
    always @(negedge clk) begin
        pop_pending = fifo_rdreq;
        if (fifo_rdreq) pop_cnt++;
        if (fifo_rdreq && fifo_rdempty) begin
            nvec++; nmis++;
            $display("FAIL rdreq_when_empty: rdreq=1 with rdempty=1, required rdreq=0");
        end
        if (!reset && av_write && !av_waitrequest) begin
            acc_cnt++;
            nvec++;
            if (exp_beats.size() == 0) begin
                nmis++;
                $display("FAIL unexpected_beat: addr=%h data=%h be=%h, required no beat",
                         av_address, av_writedata, av_byteenable);
            end else begin
                mb = exp_beats.pop_front();
                if (av_address !== mb.addr || av_burstcount !== mb.bc ||
                    av_byteenable !== mb.be || (mb.chk_data && av_writedata !== mb.data)) begin
                    nmis++;
                    $display("FAIL beat: got addr=%h bc=%0d data=%h be=%h, required addr=%h bc=%0d data=%h be=%h",
                             av_address, av_burstcount, av_writedata, av_byteenable,
                             mb.addr, mb.bc, mb.data, mb.be);
                end
            end
        end
        if (!reset && done) begin
            done_cnt++;
            nvec++;
            if (exp_done.size() == 0) begin
                nmis++;
                $display("FAIL unexpected_done: bytes=%0d, required no done", done_bytes);
            end else begin
                md = exp_done.pop_front();
                if (done_bytes !== md.bytes || done_ovf !== md.ovf || done_err !== md.err) begin
                    nmis++;
                    $display("FAIL done: got bytes=%0d ovf=%b err=%b, required bytes=%0d ovf=%b err=%b",
                             done_bytes, done_ovf, done_err, md.bytes, md.ovf, md.err);
                end
            end
        end
        while (chk_q.size() > 0) begin
            mc = chk_q.pop_front();
            nvec++;
            if (mc.act !== mc.exp) begin
                nmis++;
                $display("FAIL %s: got %0h, required %0h", mc.name, mc.act, mc.exp);
            end
        end
    end

    task automatic reset_checks(input string p);
        check({p, "_av_write"}, 64'(av_write), 64'd0);
        check({p, "_av_address"}, 64'(av_address), 64'd0);
        check({p, "_av_burstcount"}, 64'(av_burstcount), 64'd0);
        check({p, "_av_byteenable"}, 64'(av_byteenable), 64'd0);
        check({p, "_av_writedata"}, 64'(av_writedata), 64'd0);
        check({p, "_done"}, 64'(done), 64'd0);
        check({p, "_done_bytes"}, 64'(done_bytes), 64'd0);
        check({p, "_done_ovf"}, 64'(done_ovf), 64'd0);
        check({p, "_done_err"}, 64'(done_err), 64'd0);
        check({p, "_desc_ready"}, 64'(desc_ready), 64'd1);
    endtask

    task automatic send_desc(input logic [31:0] addr, input logic [15:0] len);
        @(negedge clk);
        check("desc_ready", 64'(desc_ready), 64'd1);
        desc_valid = 1'b1; desc_addr = addr; desc_len = len;
        @(negedge clk);
        desc_valid = 1'b0;
    endtask

    task automatic run_frame(input string nm, input logic [31:0] addr, input logic [15:0] len,
                             input int exp_pops, input int exp_left);
        int d0;
        int p0;
        d0 = done_cnt;
        p0 = pop_cnt;
        send_desc(addr, len);
        for (int i = 0; i < 600 && done_cnt == d0; i++) @(negedge clk);
        check({nm, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
        repeat (2) @(negedge clk);
        check({nm, "_pops"}, 64'(pop_cnt - p0), 64'(exp_pops));
        check({nm, "_fifo_left"}, 64'(fq.size()), 64'(exp_left));
        check({nm, "_beats_pending"}, 64'(exp_beats.size()), 64'd0);
    endtask

    initial begin
        int acc0;
        int p0;
        repeat (3) @(negedge clk);
        reset_checks("rst");
        reset = 1'b0;

        // Two full 8-beat bursts
        for (int i = 0; i < 16; i++) begin
            push(mkw(32'hA000_0000 + 32'(i), 1'(i == 15), 2'd3, 1'b0));
            exp_beat(32'h1000_0000 + ((i < 8) ? 32'd0 : 32'd32), 4'd8,
                     32'hA000_0000 + 32'(i), 4'hF, 1'b1);
        end
        frame_done = 1'b1;
        exp_fin(16'd64, 1'b0, 1'b0);
        run_frame("full", 32'h1000_0000, 16'd64, 16, 0);

        // Short frame: 5 words, 2 bytes in the last
        for (int i = 0; i < 5; i++) begin
            push(mkw(32'hB000_0000 + 32'(i), 1'(i == 4), 2'd1, 1'b0));
            exp_beat(32'h2000_0040, 4'd5, 32'hB000_0000 + 32'(i), (i == 4) ? 4'b0011 : 4'hF, 1'b1);
        end
        exp_fin(16'd18, 1'b0, 1'b0);
        run_frame("short", 32'h2000_0041, 16'd64, 5, 0);

        // Pad beats: next frame's words push rdusedw to 9, so 3 real + 5 pad beats
        for (int i = 0; i < 3; i++) begin
            push(mkw(32'hC000_0000 + 32'(i), 1'(i == 2), 2'd2, 1'b0));
            exp_beat(32'h3000_0100, 4'd8, 32'hC000_0000 + 32'(i), (i == 2) ? 4'b0111 : 4'hF, 1'b1);
        end
        for (int i = 0; i < 5; i++) exp_beat(32'h3000_0100, 4'd8, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 6; i++) push(mkw(32'hD000_0000 + 32'(i), 1'(i == 5), 2'd0, 1'b0));
        exp_fin(16'd11, 1'b0, 1'b0);
        run_frame("pad", 32'h3000_0100, 16'd64, 3, 6);

        for (int i = 0; i < 6; i++)
            exp_beat(32'h3000_0200, 4'd6, 32'hD000_0000 + 32'(i), (i == 5) ? 4'b0001 : 4'hF, 1'b1);
        exp_fin(16'd21, 1'b0, 1'b0);
        run_frame("next", 32'h3000_0200, 16'd64, 6, 0);

        // Overflow: 8-byte buffer, 6-word frame
        for (int i = 0; i < 6; i++) push(mkw(32'hE000_0000 + 32'(i), 1'(i == 5), 2'd3, 1'b0));
        for (int i = 0; i < 2; i++) exp_beat(32'h4000_0000, 4'd2, 32'hE000_0000 + 32'(i), 4'hF, 1'b1);
        exp_fin(16'd8, 1'b1, 1'b0);
        run_frame("ovf", 32'h4000_0000, 16'd8, 6, 0);

        // Zero-length buffer: whole frame discarded, error bit on a discarded word
        push(mkw(32'hF000_0000, 1'b0, 2'd0, 1'b1));
        push(mkw(32'hF000_0001, 1'b1, 2'd0, 1'b0));
        exp_fin(16'd0, 1'b1, 1'b1);
        run_frame("len0", 32'h5000_0000, 16'd0, 2, 0);

        // Random slave stalls over an 8-beat burst
        for (int i = 0; i < 8; i++) begin
            push(mkw(32'h6600_0000 + 32'(i), 1'(i == 7), 2'd3, 1'b0));
            exp_beat(32'h6000_0000, 4'd8, 32'h6600_0000 + 32'(i), 4'hF, 1'b1);
        end
        exp_fin(16'd32, 1'b0, 1'b0);
        stall_en = 1'b1;
        run_frame("stall", 32'h6000_0000, 16'd32, 8, 0);
        stall_en = 1'b0;

        // Error bit on word 3
        for (int i = 0; i < 4; i++) begin
            push(mkw(32'h7700_0000 + 32'(i), 1'(i == 3), 2'd2, 1'(i == 2)));
            exp_beat(32'h7000_0000, 4'd4, 32'h7700_0000 + 32'(i), (i == 3) ? 4'b0111 : 4'hF, 1'b1);
        end
        exp_fin(16'd15, 1'b0, 1'b1);
        run_frame("err", 32'h7000_0000, 16'd16, 4, 0);

        // Reset while beat 4 of 8 is on the bus
        for (int i = 0; i < 8; i++) push(mkw(32'h8800_0000 + 32'(i), 1'(i == 7), 2'd3, 1'b0));
        for (int i = 0; i < 3; i++) exp_beat(32'h8000_0000, 4'd8, 32'h8800_0000 + 32'(i), 4'hF, 1'b1);
        acc0 = acc_cnt;
        p0 = pop_cnt;
        send_desc(32'h8000_0000, 16'd32);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (acc_cnt - acc0 == 3 && av_write) break;
        end
        check("midrst_beat4_reached", 64'(acc_cnt - acc0 == 3 && av_write), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_checks("midrst");
        check("midrst_fifo_left", 64'(fq.size()), 64'd5);
        check("midrst_pops", 64'(pop_cnt - p0), 64'd3);
        check("midrst_beats_pending", 64'(exp_beats.size()), 64'd0);
        reset = 1'b0;
        frame_done = 1'b0;
        fq.delete();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
